// File: rtl/ifu_inst_queue.sv
// ifu_inst_queue
//   Instruction queue between the fetch controller and the IDU. Buffers
//   fetched {pc, inst} pairs so fetch can run ahead of decode, flags
//   non-32-bit encodings for the IDU and drops all entries on a redirect.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset; clears pointers and storage
//   flush_i      synchronous redirect; discards every entry
//   in_pc_i      PC of the incoming instruction
//   in_inst_i    incoming instruction word
//   in_valid_i   incoming entry valid
//   in_ready_o   queue can accept (not full)
//   out_pc_o     PC of the head entry
//   out_inst_o   instruction of the head entry
//   out_ill_o    head instruction is not a 32-bit encoding
//   out_valid_o  head entry valid (not empty)
//   out_ready_i  IDU accepts the head entry
//   count_o      number of occupied entries, 0..DEPTH
module ifu_inst_queue #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [31:0]   in_pc_i,
  input  logic [31:0]   in_inst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [31:0]   out_pc_o,
  output logic [31:0]   out_inst_o,
  output logic          out_ill_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_idx == w_rd_idx) & (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Ready is deliberately independent of out_ready_i: no push-on-pop when full.
  assign in_ready_o  = ~w_full;
  assign out_valid_o = ~w_empty;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  assign out_pc_o   = r_pc_mem[w_rd_idx];
  assign out_inst_o = r_inst_mem[w_rd_idx];
  assign out_ill_o  = out_valid_o & (out_inst_o[1:0] != 2'b11);
  assign count_o    = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Redirect wins over this cycle's push and pop.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[w_wr_idx]   <= in_pc_i;
        r_inst_mem[w_wr_idx] <= in_inst_i;
        r_wr_ptr             <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

endmodule
